// File: rtl/rv_div_pkg.sv
// Shared types and constants for the RV32M iterative divide unit.
package rv_div_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    localparam int          DIV_CNT_W = 5;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES  = 32'hFFFF_FFFF;

endpackage

// File: rtl/rv_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial subtract, restore on borrow.
module rv_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic            dividend_msb,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic            q_bit
);
    logic [XLEN-1:0] shifted;
    logic [XLEN:0]   diff;

    assign shifted = {rem[XLEN-2:0], dividend_msb};
    assign diff    = {1'b0, shifted} - {1'b0, divisor};

    // The bit shifted out of rem carries weight 2^XLEN, so when it is set the
    // shifted value always exceeds the divisor and the low bits of diff are exact.
    assign q_bit    = rem[XLEN-1] | ~diff[XLEN];
    assign rem_next = q_bit ? diff[XLEN-1:0] : shifted;

endmodule

// File: rtl/rv_div_unit.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit (restoring radix-2, then sign fixup).
// Build option RV_DIV_EARLY_OUT_EN: finish immediately when |a| < |b|.
import rv_div_pkg::*;

module rv_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [1:0]      i_div_op,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    input  logic            i_flush,
    output logic            o_busy,
    output logic            o_valid,
    output logic [XLEN-1:0] o_div_data
);
    // state | meaning
    // IDLE  | waiting for i_start
    // CALC  | one quotient bit per cycle, cnt XLEN-1 down to 0
    // FIX   | sign fixup, register result
    // DONE  | o_valid strobe
    div_state_e state, next_state;

    div_op_e              op;
    logic [XLEN-1:0]      dividend, divisor, rem, quo, div_data;
    logic [DIV_CNT_W-1:0] cnt;
    logic                 q_neg, r_neg;

    div_op_e         op_in;
    logic            is_signed, is_rem, div_zero, overflow, special, early;
    logic [XLEN-1:0] mag_a, mag_b, special_res, early_res, fixed_res;
    logic [XLEN-1:0] step_rem;
    logic            step_q;
    logic            accept;

    assign op_in     = div_op_e'(i_div_op);
    assign is_signed = (op_in == DIV) || (op_in == REM);
    assign is_rem    = (op_in == REM) || (op_in == REMU);
    assign mag_a     = (is_signed && i_op_a[XLEN-1]) ? -i_op_a : i_op_a;
    assign mag_b     = (is_signed && i_op_b[XLEN-1]) ? -i_op_b : i_op_b;
    assign div_zero  = (i_op_b == '0);
    assign overflow  = is_signed && (i_op_a == INT_MIN) && (i_op_b == ALL_ONES);
    assign special   = div_zero || overflow;

    always_comb begin
        special_res = '0;
        if (div_zero) special_res = is_rem ? i_op_a : ALL_ONES;
        else          special_res = is_rem ? '0 : INT_MIN;
    end

`ifdef RV_DIV_EARLY_OUT_EN
    assign early = !special && (mag_a < mag_b);
`else
    assign early = 1'b0;
`endif
    assign early_res = is_rem ? i_op_a : '0;
    assign accept    = (state == IDLE) && i_start && !i_flush;

    rv_div_step #(.XLEN(XLEN)) u_step (
        .rem          (rem),
        .dividend_msb (dividend[XLEN-1]),
        .divisor      (divisor),
        .rem_next     (step_rem),
        .q_bit        (step_q)
    );

    always_comb begin
        fixed_res = '0;
        if ((op == REM) || (op == REMU)) fixed_res = r_neg ? -rem : rem;
        else                             fixed_res = q_neg ? -quo : quo;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        o_busy     = 1'b0;
        o_valid    = 1'b0;
        case (state)
            IDLE: if (i_start) next_state = (special || early) ? DONE : CALC;
            CALC: begin
                o_busy = 1'b1;
                if (cnt == '0) next_state = FIX;
            end
            FIX: begin
                o_busy     = 1'b1;
                next_state = DONE;
            end
            DONE: begin
                o_valid    = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (i_flush) next_state = IDLE;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            op       <= DIV;
            dividend <= '0;
            divisor  <= '0;
            rem      <= '0;
            quo      <= '0;
            cnt      <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            div_data <= '0;
        end else begin
            if (accept) begin
                op       <= op_in;
                dividend <= mag_a;
                divisor  <= mag_b;
                rem      <= '0;
                quo      <= '0;
                cnt      <= DIV_CNT_W'(XLEN-1);
                q_neg    <= is_signed && (i_op_a[XLEN-1] ^ i_op_b[XLEN-1]);
                r_neg    <= is_signed && i_op_a[XLEN-1];
                if (special)    div_data <= special_res;
                else if (early) div_data <= early_res;
            end
            if (state == CALC) begin
                rem      <= step_rem;
                quo      <= {quo[XLEN-2:0], step_q};
                dividend <= dividend << 1;
                cnt      <= cnt - 1'b1;
            end
            if ((state == FIX) && !i_flush) div_data <= fixed_res;
        end
    end

    assign o_div_data = div_data;

endmodule

// File: tb/tb_rv_div_unit.sv
// Self-checking bench for rv_div_unit: directed table, abort sequences, random vs. arithmetic model.
module tb_rv_div_unit;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [1:0]  i_div_op = 2'd0;
    logic [31:0] i_op_a = '0;
    logic [31:0] i_op_b = '0;
    logic        i_flush = 1'b0;
    logic        o_busy, o_valid;
    logic [31:0] o_div_data;

    int checks = 0;
    int errors = 0;

    rv_div_unit #(.XLEN(32)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_div_op   (i_div_op),
        .i_op_a     (i_op_a),
        .i_op_b     (i_op_b),
        .i_flush    (i_flush),
        .o_busy     (o_busy),
        .o_valid    (o_valid),
        .o_div_data (o_div_data)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // RISC-V M-extension semantics from plain integer arithmetic
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            2'd0: if (b == 0) return 32'hFFFF_FFFF;
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                  else return 32'(sa / sb);
            2'd1: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'd2: if (b == 0) return a;
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                  else return 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bit     sgn;
        longint ma, mb;
        sgn = (op == 2'd0) || (op == 2'd2);
        ma  = (sgn && a[31]) ? 64'h1_0000_0000 - longint'(a) : longint'(a);
        mb  = (sgn && b[31]) ? 64'h1_0000_0000 - longint'(b) : longint'(b);
        if (b == 0) return 1;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef RV_DIV_EARLY_OUT_EN
        if (ma < mb) return 1;
`endif
        return (ma >= 0 && mb >= 0) ? 34 : 0;
    endfunction

    // Caller is #1 after a rising edge; start is sampled at the next edge.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input string name, input bit inject);
        logic [31:0] prev;
        prev     = o_div_data;
        i_div_op = op;
        i_op_a   = a;
        i_op_b   = b;
        i_start  = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        for (int c = 1; c <= lat; c++) begin
            if (c > 1) begin
                @(posedge i_clk); #1;
            end
            if (inject && c == 5) begin
                i_start  = 1'b1;
                i_op_a   = ~a;
                i_op_b   = a ^ b;
                i_div_op = ~op;
            end
            if (inject && c == 6) i_start = 1'b0;
            if (c < lat) begin
                check({name, " busy"}, {31'd0, o_busy}, 32'd1);
                check({name, " early valid"}, {31'd0, o_valid}, 32'd0);
            end else begin
                check({name, " busy at done"}, {31'd0, o_busy}, 32'd0);
                check({name, " valid"}, {31'd0, o_valid}, 32'd1);
                check({name, " data"}, o_div_data, exp);
            end
        end
        @(posedge i_clk); #1;
        check({name, " valid one cycle"}, {31'd0, o_valid}, 32'd0);
        check({name, " data held"}, o_div_data, exp);
        if (prev === 32'hx) check({name, " prev"}, prev, 32'd0);
    endtask

    task automatic step_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge i_clk); #1;
        end
    endtask

    vec_t vecs[15];

    initial begin
        vecs[0]  = '{2'd1, 32'd100,        32'd7,          32'd14,         "divu_100_7"};
        vecs[1]  = '{2'd3, 32'd100,        32'd7,          32'd2,          "remu_100_7"};
        vecs[2]  = '{2'd0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  "div_m7_2"};
        vecs[3]  = '{2'd2, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  "rem_m7_2"};
        vecs[4]  = '{2'd1, 32'd5,          32'd0,          32'hFFFF_FFFF,  "divu_by0"};
        vecs[5]  = '{2'd2, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  "rem_by0"};
        vecs[6]  = '{2'd0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  "div_ovf"};
        vecs[7]  = '{2'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          "rem_ovf"};
        vecs[8]  = '{2'd1, 32'd3,          32'd10,         32'd0,          "divu_3_10"};
        vecs[9]  = '{2'd3, 32'd3,          32'd10,         32'd3,          "remu_3_10"};
        vecs[10] = '{2'd1, 32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          "divu_big"};
        vecs[11] = '{2'd3, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE,  "remu_big"};
        vecs[12] = '{2'd0, 32'h8000_0000,  32'd2,          32'hC000_0000,  "div_min_2"};
        vecs[13] = '{2'd2, 32'd7,          32'hFFFF_FFFE,  32'd1,          "rem_7_m2"};
        vecs[14] = '{2'd0, 32'hFFFF_FFFD,  32'd10,         32'd0,          "div_m3_10"};

        #1;
        check("reset busy",  {31'd0, o_busy},  32'd0);
        check("reset valid", {31'd0, o_valid}, 32'd0);
        check("reset data",  o_div_data,       32'd0);
        #12 i_rst = 1'b0;
        @(posedge i_clk); #1;

        for (int i = 0; i < 15; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
                   latency(vecs[i].op, vecs[i].a, vecs[i].b), vecs[i].name, 1'b0);

        // flush during CALC, then a fresh start one cycle after returning to IDLE
        i_div_op = 2'd1; i_op_a = 32'd1000; i_op_b = 32'd3; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        step_cycles(9);
        check("flush calc busy before", {31'd0, o_busy}, 32'd1);
        i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        check("flush calc idle", {31'd0, o_busy},  32'd0);
        check("flush calc valid", {31'd0, o_valid}, 32'd0);
        @(posedge i_clk); #1;
        run_op(2'd1, 32'd1000, 32'd3, 32'd333, 34, "after_flush", 1'b0);

        // flush during FIX wins over completion; result discarded
        i_div_op = 2'd1; i_op_a = 32'd999; i_op_b = 32'd10; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        step_cycles(32);
        check("flush fix busy before", {31'd0, o_busy}, 32'd1);
        i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        check("flush fix valid", {31'd0, o_valid}, 32'd0);
        check("flush fix busy",  {31'd0, o_busy},  32'd0);
        check("flush fix data kept", o_div_data, 32'd333);

        // simultaneous start and flush in IDLE: start ignored
        i_div_op = 2'd1; i_op_a = 32'd50; i_op_b = 32'd0; i_start = 1'b1; i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0; i_flush = 1'b0;
        check("start+flush busy",  {31'd0, o_busy},  32'd0);
        check("start+flush valid", {31'd0, o_valid}, 32'd0);

        // async reset mid-CALC
        i_div_op = 2'd1; i_op_a = 32'd12345; i_op_b = 32'd17; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        step_cycles(9);
        #2 i_rst = 1'b1;
        #1;
        check("async rst busy",  {31'd0, o_busy},  32'd0);
        check("async rst valid", {31'd0, o_valid}, 32'd0);
        check("async rst data",  o_div_data,       32'd0);
        #1 i_rst = 1'b0;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 40; i++) begin
                @(posedge i_clk); #1;
                if (o_valid || o_busy) seen++;
            end
            check("no activity after rst", seen, 32'd0);
        end

        // random operations against the arithmetic model
        for (int n = 0; n < 60; n++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            int          lat;
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'($urandom_range(0, 255));
                4: b = -32'($urandom_range(1, 9));
                default: ;
            endcase
            lat = latency(op, a, b);
            run_op(op, a, b, model(op, a, b), lat, $sformatf("rnd%0d", n), lat > 10);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_div_unit.md
Name: rv_div_unit

Overview:
- Iterative, multi-cycle RV32M divide/remainder unit that sits beside the single-cycle execute ALU in the EX stage.
- Accepts operands with a start pulse and holds `o_busy` while iterating, so the hazard unit stalls the pipeline.
- Returns the quotient or remainder with a one-cycle valid pulse for writeback.
- Restoring radix-2 algorithm: one quotient bit per cycle on operand magnitudes, then sign fixup.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  request; sampled only in IDLE.
- i_div_op  in  2  0=DIV, 1=DIVU, 2=REM, 3=REMU.
- i_op_a  in  XLEN  dividend (rs1).
- i_op_b  in  XLEN  divisor (rs2).
- i_flush  in  1  pipeline flush; aborts the operation in flight.
- o_busy  out  1  high in CALC and FIX states; pipeline stall request.
- o_valid  out  1  one-cycle result strobe.
- o_div_data  out  XLEN  result; valid only while o_valid=1.

Behaviour:
- Reset (async, i_rst=1): state=IDLE; o_busy=0; o_valid=0; o_div_data=0; internal quotient, remainder, counter and flags cleared.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On i_start=1 (and i_flush=0), latch op, operand magnitudes, result sign, remainder sign, and the special-case flags.
  - Signed ops (DIV, REM) take |a| and |b|; |-2^31| = 0x80000000 treated as unsigned.
  - Quotient sign = a[31]^b[31]; remainder sign = a[31].
- Divide-by-zero (b=0): go straight to DONE; no iterations.
  - DIV/DIVU → 0xFFFFFFFF.
  - REM/REMU → a.
- Signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF): go straight to DONE.
  - DIV → 0x80000000.
  - REM → 0.
- CALC:
  - Counter runs XLEN-1 down to 0.
  - Each cycle: rem' = {rem[XLEN-2:0], dividend msb}; shift the dividend left.
  - If rem' >= |b|: rem = rem' - |b| and quotient bit = 1; otherwise rem = rem' and quotient bit = 0.
  - Subtract width is XLEN+1 so the borrow is the compare result.
  - After the counter=0 cycle → FIX.
- FIX: one cycle. Apply two's-complement negation to the quotient or remainder if the corresponding sign flag is set (signed ops only), then register into o_div_data → DONE.
- DONE: o_valid=1 for exactly one cycle, then → IDLE. o_div_data holds its value until the next DONE.
- Latency, counting the start edge as cycle 0:
  - Normal path: CALC on cycles 1..32, FIX on 33, o_valid on 34.
  - Special cases: o_valid on cycle 1.
- o_busy is 1 in CALC and FIX, and 0 in IDLE and DONE.
- i_start while not IDLE is ignored; no queueing.
- i_flush=1 in any state: next state IDLE, o_valid=0 next cycle, result discarded. Flush has priority over start and over completion.
- Simultaneous i_start and i_flush in IDLE: start ignored.
- Reset asserted mid-operation: immediate return to reset values; no valid pulse is produced.

Optional Feature:
- Macro: RV_DIV_EARLY_OUT_EN.
- Defined: in IDLE, if |a| < |b| (and not a special case), skip CALC and FIX.
  - Go to DONE with quotient 0 and remainder a (original signed value).
  - o_valid on cycle 1.
  - Each normal operation shortens by zero further cycles (FIX is kept).
- Undefined: every non-special operation takes the full 34-cycle path.
- Results are identical in both builds; only latency differs.

Decomposition:
- Shared package rv_div_pkg holds:
  - div_op_e enum: DIV, DIVU, REM, REMU.
  - div_state_e enum: IDLE, CALC, FIX, DONE.
  - XLEN-derived constants: DIV_CNT_W=5, INT_MIN=0x80000000, ALL_ONES=0xFFFFFFFF.
- One sub-module, rv_div_step: purely combinational single iteration.
  - Inputs: rem, dividend msb, divisor.
  - Outputs: next rem, quotient bit, computed via an XLEN+1-bit subtract.
  - Instantiated once and reused each CALC cycle.

Test Plan:
- DIVU: a=100, b=7, start → o_valid on cycle 34, o_div_data=14; o_busy high cycles 1–33. REMU with the same operands → 2.
- Signed: DIV a=-7 (0xFFFFFFF9), b=2 → 0xFFFFFFFD (-3). REM with the same operands → 0xFFFFFFFF (-1). Truncation toward zero.
- Divide by zero: DIVU a=5, b=0 → 0xFFFFFFFF on cycle 1. REM a=-5, b=0 → 0xFFFFFFFB on cycle 1.
- Overflow: DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000 on cycle 1. REM with the same operands → 0.
- Abort cases:
  - Flush at cycle 10 of a DIVU → IDLE at cycle 11, no o_valid ever; a fresh start at cycle 12 completes correctly at cycle 46.
  - Async reset pulse mid-CALC → all outputs 0 immediately.
- Early-out: with RV_DIV_EARLY_OUT_EN defined, DIVU a=3, b=10 → 0 on cycle 1. Undefined → 0 on cycle 34. REMU with the same operands → 3.
